// File: rtl/vc_test_sink_rr_arbiter_if.sv
// Val/rdy bundle between N upstream sources, the round-robin arbiter and
// one downstream test sink. The slave modport is the arbiter's view and
// the master modport is the harness view that drives sources and the sink.
interface vc_test_sink_rr_arbiter_if #(
    parameter int p_msg_nbits = 8,
    parameter int p_num_reqs  = 4,
    parameter int p_id_nbits  = 2
);
    logic [p_num_reqs-1:0]             in_val;
    logic [p_num_reqs-1:0]             in_rdy;
    logic [p_num_reqs*p_msg_nbits-1:0] in_msg;
    logic                              out_val;
    logic                              out_rdy;
    logic [p_msg_nbits-1:0]            out_msg;
    logic [p_id_nbits-1:0]             out_id;
    logic [31:0]                       num_xfers;

    modport slave (
        input  in_val, in_msg, out_rdy,
        output in_rdy, out_val, out_msg, out_id, num_xfers
    );

    modport master (
        output in_val, in_msg, out_rdy,
        input  in_rdy, out_val, out_msg, out_id, num_xfers
    );
endinterface

// File: rtl/vc_test_sink_rr_arbiter.sv
// Round-robin arbiter feeding one val/rdy test sink from p_num_reqs sources.
// The winner is captured in a one-entry buffer together with its source
// index, so the sink side can check ordering per source. The buffer can be
// refilled on the same edge it drains, sustaining one message per cycle.
module vc_test_sink_rr_arbiter #(
    parameter int p_msg_nbits = 8,
    parameter int p_num_reqs  = 4,
    parameter int p_id_nbits  = 2
) (
    input logic                     clk,
    input logic                     reset,
    vc_test_sink_rr_arbiter_if.slave bus
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [p_id_nbits-1:0] LAST_ID = p_id_nbits'(p_num_reqs - 1);

    // Buffer stage registers
    logic [0:0]             state_p1;
    logic [p_msg_nbits-1:0] msg_p1;
    logic [p_id_nbits-1:0]  id_p1;
    logic [p_id_nbits-1:0]  ptr;
    logic [31:0]            xfer_cnt;

    logic                   vld_p1;
    logic                   deq;
    logic                   accept;
    logic                   any_val;
    logic                   enq;
    logic [p_num_reqs-1:0]  rot_val;
    int                     offset;
    int                     grant_sum;
    logic [p_id_nbits-1:0]  grant;
    logic [p_id_nbits-1:0]  ptr_nxt;
    logic [p_msg_nbits-1:0] sel_msg;
    logic [p_num_reqs-1:0]  in_rdy_c;

    assign vld_p1  = (state_p1 == ST_FULL);
    assign deq     = vld_p1 & bus.out_rdy;
    assign accept  = ~vld_p1 | deq;
    assign any_val = |bus.in_val;
    // While reset is held nothing is accepted, so no source sees a handshake.
    assign enq     = reset & any_val & accept;

    // Rotate requests so the search always starts at bit 0, take the lowest
    // set bit, then rotate the offset back into a requester index.
    always_comb begin
        rot_val   = p_num_reqs'({bus.in_val, bus.in_val} >> ptr);
        offset    = 0;
        grant_sum = 0;
        for (int k = p_num_reqs - 1; k >= 0; k--) begin
            if (rot_val[k]) begin
                offset = k;
            end
        end
        grant_sum = int'(ptr) + offset;
        if (grant_sum >= p_num_reqs) begin
            grant_sum = grant_sum - p_num_reqs;
        end
        grant = p_id_nbits'(grant_sum);
    end

    // Priority moves to the requester just after the winner, wrapping at the end.
    always_comb begin
        ptr_nxt = (grant == LAST_ID) ? '0 : grant + p_id_nbits'(1);
    end

    // Select the winner's message and raise ready for the winner only.
    always_comb begin
        sel_msg  = '0;
        in_rdy_c = '0;
        for (int i = 0; i < p_num_reqs; i++) begin
            if (grant == p_id_nbits'(i)) begin
                sel_msg     = bus.in_msg[i*p_msg_nbits +: p_msg_nbits];
                in_rdy_c[i] = enq & bus.in_val[i];
            end
        end
    end

    // Buffer fill/drain and priority pointer update; a fill wins over a drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p1 <= ST_EMPTY;
            msg_p1   <= '0;
            id_p1    <= '0;
            ptr      <= '0;
        end else if (enq) begin
            state_p1 <= ST_FULL;
            msg_p1   <= sel_msg;
            id_p1    <= grant;
            ptr      <= ptr_nxt;
        end else if (deq) begin
            state_p1 <= ST_EMPTY;
        end
    end

    // Count completed output handshakes; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xfer_cnt <= '0;
        end else if (deq) begin
            xfer_cnt <= xfer_cnt + 32'd1;
        end
    end

    assign bus.in_rdy    = in_rdy_c;
    assign bus.out_val   = vld_p1;
    assign bus.out_msg   = msg_p1;
    assign bus.out_id    = id_p1;
    assign bus.num_xfers = xfer_cnt;

endmodule
